// File: rtl/huff_bit_buffer_if.sv
// rtl/huff_bit_buffer_if.sv - byte input, bit window and status signals of the Huffman bit buffer
interface huff_bit_buffer_if;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic [15:0] window;
    logic       window_valid;
    logic [5:0] bit_count;
    logic       consume;
    logic [4:0] consume_len;
    logic       flush;
    logic       marker_seen;
    logic [7:0] marker;
    logic       underflow_err;

    modport master (
        output in_byte, in_valid, consume, consume_len, flush,
        input  in_ready, window, window_valid, bit_count, marker_seen, marker, underflow_err
    );

    modport slave (
        input  in_byte, in_valid, consume, consume_len, flush,
        output in_ready, window, window_valid, bit_count, marker_seen, marker, underflow_err
    );
endinterface

// File: rtl/huff_bit_buffer.sv
// rtl/huff_bit_buffer.sv - 32-bit entropy-coded bit buffer; BYTE_UNSTUFF_EN adds JPEG 0xFF00 unstuffing and marker detection
module huff_bit_buffer (
    input logic            clock,
    input logic            reset,
    huff_bit_buffer_if.slave bus
);

`ifdef BYTE_UNSTUFF_EN
    typedef enum logic [1:0] {NORMAL, GOT_FF, MARKER} state_t;
    state_t     state, state_next;
    logic [7:0] marker_q, marker_next;
    logic       marker_seen_q, marker_seen_next;
`endif

    logic [31:0] buffer, buffer_next;
    logic [5:0]  count, count_next;
    logic        underflow_q, underflow_next;
    logic        ready, xfer, consume_ok, append;
    logic [7:0]  append_byte;
    logic [31:0] shifted;
    logic [5:0]  count_sh;
    logic [15:0] valid_mask;

    // Stream is MSB-first, buffer is LSB-first, so each byte lands bit-reversed.
    function automatic logic [7:0] bit_rev(input logic [7:0] b);
        for (int i = 0; i < 8; i++) bit_rev[i] = b[7-i];
    endfunction

    always_comb begin
        ready = (count <= 6'd24) && !bus.flush;
`ifdef BYTE_UNSTUFF_EN
        ready = ready && (state != MARKER);
`endif
        xfer        = bus.in_valid && ready;
        consume_ok  = bus.consume && ({1'b0, bus.consume_len} <= count);
        shifted     = consume_ok ? (buffer >> bus.consume_len) : buffer;
        count_sh    = consume_ok ? (count - {1'b0, bus.consume_len}) : count;
        append      = 1'b0;
        append_byte = bus.in_byte;
`ifdef BYTE_UNSTUFF_EN
        state_next       = state;
        marker_next      = marker_q;
        marker_seen_next = marker_seen_q;
        case (state)
            NORMAL: if (xfer) begin
                if (bus.in_byte == 8'hFF) state_next = GOT_FF;
                else                      append     = 1'b1;
            end
            GOT_FF: if (xfer) begin
                if (bus.in_byte == 8'h00) begin
                    append      = 1'b1;
                    append_byte = 8'hFF;
                    state_next  = NORMAL;
                end else if (bus.in_byte != 8'hFF) begin
                    marker_next      = bus.in_byte;
                    marker_seen_next = 1'b1;
                    state_next       = MARKER;
                end
            end
            default: ;
        endcase
`else
        append = xfer;
`endif
        // Bits above count are always zero, so the new byte can be OR-ed in after the shift.
        buffer_next    = shifted | (append ? ({24'b0, bit_rev(append_byte)} << count_sh) : 32'b0);
        count_next     = count_sh + (append ? 6'd8 : 6'd0);
        underflow_next = underflow_q | (bus.consume && !consume_ok);
        if (bus.flush) begin
            buffer_next    = 32'b0;
            count_next     = 6'd0;
            underflow_next = 1'b0;
`ifdef BYTE_UNSTUFF_EN
            state_next       = NORMAL;
            marker_seen_next = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            buffer      <= 32'b0;
            count       <= 6'd0;
            underflow_q <= 1'b0;
`ifdef BYTE_UNSTUFF_EN
            state         <= NORMAL;
            marker_q      <= 8'h00;
            marker_seen_q <= 1'b0;
`endif
        end else begin
            buffer      <= buffer_next;
            count       <= count_next;
            underflow_q <= underflow_next;
`ifdef BYTE_UNSTUFF_EN
            state         <= state_next;
            marker_q      <= marker_next;
            marker_seen_q <= marker_seen_next;
`endif
        end
    end

    // Positions not yet filled read as 1 (JPEG fill bits).
    assign valid_mask        = (count >= 6'd16) ? 16'hFFFF : ((16'd1 << count[3:0]) - 16'd1);
    assign bus.window        = buffer[15:0] | ~valid_mask;
    assign bus.in_ready      = ready;
    assign bus.bit_count     = count;
    assign bus.underflow_err = underflow_q;
`ifdef BYTE_UNSTUFF_EN
    assign bus.window_valid = (count >= 6'd16) || ((state == MARKER) && (count != 6'd0));
    assign bus.marker       = marker_q;
    assign bus.marker_seen  = marker_seen_q;
`else
    assign bus.window_valid = (count >= 6'd16);
    assign bus.marker       = 8'h00;
    assign bus.marker_seen  = 1'b0;
`endif

endmodule

// File: tb/tb_huff_bit_buffer.sv
// tb/tb_huff_bit_buffer.sv - directed self-checking bench for huff_bit_buffer (both BYTE_UNSTUFF_EN builds)
module tb_huff_bit_buffer;
    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    huff_bit_buffer_if bus();

    huff_bit_buffer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic eat(input logic [4:0] n);
        bus.consume     = 1'b1;
        bus.consume_len = n;
        tick();
        bus.consume = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.in_byte     = 8'h00;
        bus.in_valid    = 1'b0;
        bus.consume     = 1'b0;
        bus.consume_len = 5'd0;
        bus.flush       = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_in_ready",  bus.in_ready, 1);
        chk("rst_window",    bus.window, 16'hFFFF);
        chk("rst_wvalid",    bus.window_valid, 0);
        chk("rst_count",     bus.bit_count, 0);
        chk("rst_marker_seen", bus.marker_seen, 0);
        chk("rst_marker",    bus.marker, 8'h00);
        chk("rst_underflow", bus.underflow_err, 0);

        push(8'hA5);
        push(8'h3C);
        chk("a5_3c_count",  bus.bit_count, 16);
        chk("a5_3c_window", bus.window, 16'h3CA5);
        chk("a5_3c_low4",   bus.window[3:0], 4'h5);
        chk("a5_3c_wvalid", bus.window_valid, 1);
        eat(5'd4);
        chk("c4_count",  bus.bit_count, 12);
        chk("c4_window", bus.window, 16'hF3CA);
        chk("c4_wvalid", bus.window_valid, 0);
        eat(5'd7);
        chk("c7_count",  bus.bit_count, 5);
        chk("c7_window", bus.window, 16'hFFE7);
        eat(5'd9);
        chk("uf_count",  bus.bit_count, 5);
        chk("uf_window", bus.window, 16'hFFE7);
        chk("uf_flag",   bus.underflow_err, 1);
        eat(5'd0);
        chk("c0_count",  bus.bit_count, 5);
        chk("uf_sticky", bus.underflow_err, 1);

        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h11;
        bus.consume  = 1'b1;
        bus.consume_len = 5'd2;
        #1;
        chk("flush_ready_low", bus.in_ready, 0);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.consume  = 1'b0;
        chk("flush_count",  bus.bit_count, 0);
        chk("flush_uf",     bus.underflow_err, 0);
        chk("flush_window", bus.window, 16'hFFFF);

        push(8'hA5);
        push(8'h3C);
        push(8'h0F);
        chk("fill24_count", bus.bit_count, 24);
        chk("fill24_ready", bus.in_ready, 1);
        bus.in_byte  = 8'h01;
        bus.in_valid = 1'b1;
        eat(5'd16);
        bus.in_valid = 1'b0;
        chk("sim_count",  bus.bit_count, 16);
        chk("sim_window", bus.window, 16'h80F0);
        push(8'h22);
        push(8'h33);
        chk("full_count", bus.bit_count, 32);
        chk("full_ready", bus.in_ready, 0);
        push(8'h44);
        chk("full_hold",  bus.bit_count, 32);
        do_flush();

        bus.in_byte  = 8'h5A;
        bus.in_valid = 1'b1;
        eat(5'd3);
        bus.in_valid = 1'b0;
        chk("ufb_count",  bus.bit_count, 8);
        chk("ufb_window", bus.window, 16'hFF5A);
        chk("ufb_flag",   bus.underflow_err, 1);
        do_flush();

`ifdef BYTE_UNSTUFF_EN
        push(8'hFF);
        chk("gotff_count", bus.bit_count, 0);
        push(8'h00);
        push(8'h12);
        chk("stuff_count",  bus.bit_count, 16);
        chk("stuff_window", bus.window, 16'h48FF);
        chk("stuff_low8",   bus.window[7:0], 8'hFF);
        chk("stuff_nomark", bus.marker_seen, 0);
        do_flush();

        push(8'hFF);
        push(8'hFF);
        push(8'h00);
        push(8'h12);
        chk("fillff_count",  bus.bit_count, 16);
        chk("fillff_window", bus.window, 16'h48FF);
        do_flush();

        push(8'h80);
        push(8'hFF);
        push(8'hD9);
        chk("mk_seen",   bus.marker_seen, 1);
        chk("mk_code",   bus.marker, 8'hD9);
        chk("mk_count",  bus.bit_count, 8);
        chk("mk_wvalid", bus.window_valid, 1);
        chk("mk_window", bus.window, 16'hFF01);
        chk("mk_ready",  bus.in_ready, 0);
        push(8'h77);
        chk("mk_hold",   bus.bit_count, 8);
        eat(5'd8);
        chk("mk_drain_count",  bus.bit_count, 0);
        chk("mk_drain_wvalid", bus.window_valid, 0);
        chk("mk_drain_ready",  bus.in_ready, 0);
        do_flush();
        chk("mkf_count", bus.bit_count, 0);
        chk("mkf_ready", bus.in_ready, 1);
        chk("mkf_seen",  bus.marker_seen, 0);
        chk("mkf_code",  bus.marker, 8'hD9);

        push(8'hFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_marker", bus.marker, 8'h00);
        push(8'h12);
        chk("rst2_count",  bus.bit_count, 8);
        chk("rst2_window", bus.window, 16'hFF48);
`else
        push(8'hFF);
        push(8'h00);
        chk("raw_count",  bus.bit_count, 16);
        chk("raw_window", bus.window, 16'h00FF);
        chk("raw_seen",   bus.marker_seen, 0);
        chk("raw_marker", bus.marker, 8'h00);
        push(8'hD9);
        chk("raw_d9_count", bus.bit_count, 24);
        chk("raw_d9_ready", bus.in_ready, 1);
        do_flush();
        chk("rawf_count", bus.bit_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/huff_bit_buffer.md
HUFF_BIT_BUFFER -- requirements
Module: huff_bit_buffer

Interface
REQ-001 SHALL have parameter/macro BYTE_UNSTUFF_EN (default: defined), which enables JPEG 0xFF00 unstuffing and marker detection.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_byte, input, 8, the next entropy-coded byte.
REQ-005 SHALL have port in_valid, input, 1, which qualifies in_byte.
REQ-006 SHALL have port in_ready, output, 1; a byte transfers on a cycle where in_valid && in_ready.
REQ-007 SHALL have port window, output, 16; window[0] is the oldest unconsumed stream bit, and it is the code input of the Huffman decode stage.
REQ-008 SHALL have port window_valid, output, 1, asserted when the window holds decodable bits.
REQ-009 SHALL have port bit_count, output, 6, the number of valid bits held (0..32).
REQ-010 SHALL have port consume, input, 1, a strobe that drops bits from the window.
REQ-011 SHALL have port consume_len, input, 5, the number of bits to drop (0..16).
REQ-012 SHALL have port flush, input, 1, which discards all held bits and clears the marker state (restart handling).
REQ-013 SHALL have port marker_seen, output, 1, sticky, set on a detected marker.
REQ-014 SHALL have port marker, output, 8, the marker code byte (the byte following 0xFF).
REQ-015 SHALL have port underflow_err, output, 1, sticky, set on an illegal consume.

Function
REQ-016 SHALL hold a 32-bit buffer with a bit count 0..32, packed LSB-first in stream order.
REQ-017 SHALL place an accepted byte at buffer positions bit_count..bit_count+7, with in_byte[7] at the lowest new position (MSB-first stream).
REQ-018 SHALL drive in_ready = (bit_count <= 24) && !flush && (state != MARKER).
REQ-019 SHALL, on a consume with consume_len <= bit_count, shift the buffer right by consume_len and reduce bit_count by consume_len in the same edge.
REQ-020 SHALL, on the same cycle as a consume and an accepted byte, compute next bit_count = bit_count - consume_len + 8, placing the byte after the shift.
REQ-021 SHALL, when consume_len > bit_count, ignore the consume, set underflow_err, and still accept any byte transferred that cycle.
REQ-022 SHALL treat consume with consume_len = 0 as a no-op.
REQ-023 SHALL drive window = buffer[15:0], with positions at or above bit_count forced to 1 (JPEG fill bits); window is combinational from the registers and has zero latency.
REQ-024 SHALL assert window_valid when bit_count >= 16, or when state == MARKER and bit_count > 0.
REQ-025 SHALL implement the unstuffing FSM with states NORMAL, GOT_FF and MARKER.
REQ-026 SHALL, in NORMAL, append an accepted byte != 0xFF; an accepted 0xFF moves to GOT_FF and appends nothing.
REQ-027 SHALL, in GOT_FF, treat an accepted 0x00 as a stuffed byte: append 0xFF and go to NORMAL.
REQ-028 SHALL, in GOT_FF, treat an accepted 0xFF as a fill byte: remain in GOT_FF and append nothing.
REQ-029 SHALL, in GOT_FF, treat any other accepted byte as a marker: latch it into marker, set marker_seen, go to MARKER, and append nothing.
REQ-030 SHALL, in MARKER, accept no bytes while held bits remain consumable.
REQ-031 SHALL, on flush, set bit_count = 0, buffer = 0, state = NORMAL, marker_seen = 0 and underflow_err = 0; flush has priority over a same-cycle consume and byte, and the byte is not transferred (in_ready is low).
REQ-032 SHALL keep the 0xFF append in REQ-027 within the REQ-018 room guarantee, since only one byte is appended per transfer.

Reset
REQ-033 SHALL, on a reset edge, set buffer = 0, bit_count = 0, state = NORMAL, marker = 0x00, marker_seen = 0 and underflow_err = 0.
REQ-034 SHALL, after reset, drive in_ready = 1, window = 0xFFFF and window_valid = 0.
REQ-035 SHALL let reset override flush, consume and in_valid, including mid-marker or mid-GOT_FF; any pending 0xFF is discarded.

Configuration
REQ-036 SHALL, with BYTE_UNSTUFF_EN defined, implement REQ-025..REQ-030.
REQ-037 SHALL, without BYTE_UNSTUFF_EN, append every accepted byte verbatim (including 0xFF and 0x00), remove the FSM, tie marker_seen = 0 and marker = 0x00, and have in_ready depend only on bit_count and flush.

Verification
REQ-038 SHALL cover: bytes 0xA5, 0x3C then consume 4 -> bit_count 16→12, window[3:0] = 0x5 (bits 1,0,1,0 of 0xA5 in stream order) before the consume.
REQ-039 SHALL cover: byte stream 0xFF, 0x00, 0x12 -> bit_count 16, first 8 window bits all 1, no marker_seen.
REQ-040 SHALL cover: byte stream 0x80, 0xFF, 0xD9 -> marker_seen = 1, marker = 0xD9, bit_count 8, window_valid = 1, window[15:8] = 0xFF fill, in_ready = 0; then flush -> bit_count 0, in_ready = 1.
REQ-041 SHALL cover: bit_count 24 with a simultaneous consume 16 and a byte -> bit_count 16 next cycle, ordering correct.
REQ-042 SHALL cover: bit_count 5 with consume_len 9 -> buffer unchanged and underflow_err = 1 until flush.
REQ-043 SHALL cover: a build without BYTE_UNSTUFF_EN fed 0xFF, 0x00 -> bit_count 16, window = 0x00FF pattern verbatim, marker_seen = 0.
